// File: rtl/waffle_run_controller.sv
// Run sequencer for the FAST_WAFFLE engine: resets the engine, runs it until last_inputs,
// waits a drain period, then captures waffle_val behind a valid/ack handshake.
module waffle_run_controller #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned RST_CYCLES   = 4,
    parameter int unsigned DRAIN_CYCLES = 14,
    parameter int unsigned TIMEOUT      = 32'd1 << 20,
    parameter int unsigned CNT_W        = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              result_ack,
    input  logic              eng_last_inputs,
    input  logic [DATA_W-1:0] eng_waffle_val,
    output logic              eng_rst_l,
    output logic              busy,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic [CNT_W-1:0]  run_cycles,
    output logic              timeout_err
);

    localparam int unsigned SeqMax = (RST_CYCLES > DRAIN_CYCLES) ? RST_CYCLES : DRAIN_CYCLES;
    localparam int unsigned SeqW   = (SeqMax > 1) ? $clog2(SeqMax + 1) : 1;
    localparam int unsigned TmoW   = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StResetEng,
        StRun,
        StDrain,
        StDone,
        StError
    } state_e;

    state_e             state_q, state_d;
    logic [SeqW-1:0]    cnt_q, cnt_d;
    logic [TmoW-1:0]    tmo_q, tmo_d;
    logic [DATA_W-1:0]  result_q, result_d;
    logic               result_valid_q, result_valid_d;
    logic [CNT_W-1:0]   run_cycles_q, run_cycles_d;
    logic               timeout_err_q, timeout_err_d;
    logic               eng_rst_l_q;
    logic               busy_q;

    logic               accept_start;
    logic               launch;
    logic [CNT_W-1:0]   run_inc;

    assign accept_start = start & ~abort;
    assign run_inc      = (run_cycles_q == '1) ? run_cycles_q : run_cycles_q + CNT_W'(1);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        tmo_d          = tmo_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        run_cycles_d   = run_cycles_q;
        timeout_err_d  = timeout_err_q;
        launch         = 1'b0;

        unique case (state_q)
            StIdle: begin
                launch = accept_start;
            end
            StResetEng: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (cnt_q == '0) begin
                    state_d = StRun;
                    tmo_d   = '0;
                end else begin
                    cnt_d = cnt_q - SeqW'(1);
                end
            end
            StRun: begin
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    run_cycles_d = run_inc;
                    tmo_d        = tmo_q + TmoW'(1);
                    if (eng_last_inputs) begin
                        if (DRAIN_CYCLES == 0) begin
                            result_d       = eng_waffle_val;
                            result_valid_d = 1'b1;
                            state_d        = StDone;
                        end else begin
                            // Drain spans exactly DRAIN_CYCLES cycles, capture in the last one.
                            cnt_d   = SeqW'(DRAIN_CYCLES - 1);
                            state_d = StDrain;
                        end
                    end else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
                        timeout_err_d = 1'b1;
                        state_d       = StError;
                    end
                end
            end
            StDrain: begin
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    run_cycles_d = run_inc;
                    if (cnt_q == '0) begin
                        result_d       = eng_waffle_val;
                        result_valid_d = 1'b1;
                        state_d        = StDone;
                    end else begin
                        cnt_d = cnt_q - SeqW'(1);
                    end
                end
            end
            StDone: begin
                if (accept_start) begin
                    launch         = 1'b1;
                    result_valid_d = 1'b0;
                end else if (result_ack) begin
                    result_valid_d = 1'b0;
                    state_d        = StIdle;
                end
            end
            StError: begin
                launch = accept_start;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (launch) begin
            state_d       = StResetEng;
            cnt_d         = SeqW'(RST_CYCLES - 1);
            timeout_err_d = 1'b0;
            run_cycles_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            tmo_q          <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            run_cycles_q   <= '0;
            timeout_err_q  <= 1'b0;
            eng_rst_l_q    <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            tmo_q          <= tmo_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            run_cycles_q   <= run_cycles_d;
            timeout_err_q  <= timeout_err_d;
            // Decoded from next state so the outputs line up with the state they describe.
            eng_rst_l_q    <= (state_d == StRun) || (state_d == StDrain) || (state_d == StDone);
            busy_q         <= (state_d == StResetEng) || (state_d == StRun) ||
                              (state_d == StDrain);
        end
    end

    assign eng_rst_l    = eng_rst_l_q;
    assign busy         = busy_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign run_cycles   = run_cycles_q;
    assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_waffle_run_controller.sv
// Directed bench for waffle_run_controller: one instance with a 14-cycle drain and a
// 16-cycle timeout, a second with no drain.
module tb_waffle_run_controller;

    logic        clk;
    logic        rst;
    logic        start, abort, result_ack, last;
    logic [31:0] val;
    logic        eng_rst_l, busy, result_valid, timeout_err;
    logic [31:0] result, run_cycles;

    logic        start0, ack0, last0;
    logic [31:0] val0;
    logic        eng_rst_l0, busy0, result_valid0, timeout_err0;
    logic [31:0] result0, run_cycles0;

    int nvec  = 0;
    int nfail = 0;
    int n;

    waffle_run_controller #(
        .DATA_W(32), .RST_CYCLES(4), .DRAIN_CYCLES(14), .TIMEOUT(16), .CNT_W(32)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .abort          (abort),
        .result_ack     (result_ack),
        .eng_last_inputs(last),
        .eng_waffle_val (val),
        .eng_rst_l      (eng_rst_l),
        .busy           (busy),
        .result         (result),
        .result_valid   (result_valid),
        .run_cycles     (run_cycles),
        .timeout_err    (timeout_err)
    );

    waffle_run_controller #(
        .DATA_W(32), .RST_CYCLES(4), .DRAIN_CYCLES(0), .TIMEOUT(16), .CNT_W(32)
    ) u_dut0 (
        .clk            (clk),
        .rst            (rst),
        .start          (start0),
        .abort          (1'b0),
        .result_ack     (ack0),
        .eng_last_inputs(last0),
        .eng_waffle_val (val0),
        .eng_rst_l      (eng_rst_l0),
        .busy           (busy0),
        .result         (result0),
        .result_valid   (result_valid0),
        .run_cycles     (run_cycles0),
        .timeout_err    (timeout_err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_run(output int cnt);
        cnt = 0;
        while (eng_rst_l !== 1'b1 && cnt < 40) begin
            tick();
            cnt++;
        end
    endtask

    task automatic wait_valid(output int cnt);
        cnt = 0;
        while (result_valid !== 1'b1 && cnt < 40) begin
            tick();
            cnt++;
        end
    endtask

    initial begin
        rst = 1'b1; start = 0; abort = 0; result_ack = 0; last = 0; val = 0;
        start0 = 0; ack0 = 0; last0 = 0; val0 = 0;
        tick();
        tick();
        check("rst_eng_rst_l", {31'd0, eng_rst_l}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_valid", {31'd0, result_valid}, 32'd0);
        check("rst_run_cycles", run_cycles, 32'd0);
        check("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
        rst = 1'b0;

        // Basic run: last_inputs 10 cycles after eng_rst_l rises.
        start = 1;
        tick();
        start = 0;
        for (int i = 1; i <= 4; i++) begin
            check("t1_eng_rst_low", {31'd0, eng_rst_l}, 32'd0);
            check("t1_busy", {31'd0, busy}, 32'd1);
            tick();
        end
        check("t1_eng_rst_rise", {31'd0, eng_rst_l}, 32'd1);
        for (int i = 0; i < 10; i++) tick();
        last = 1; val = 32'hDEADBEEF;
        tick();
        last = 0;
        wait_valid(n);
        check("t1_latency", n, 32'd14);
        check("t1_result", result, 32'hDEADBEEF);
        check("t1_run_cycles", run_cycles, 32'd25);
        check("t1_busy_done", {31'd0, busy}, 32'd0);
        result_ack = 1;
        tick();
        result_ack = 0;
        check("t1_ack_valid", {31'd0, result_valid}, 32'd0);
        check("t1_ack_result", result, 32'hDEADBEEF);

        // No-drain instance: capture on the first RUN cycle.
        start0 = 1;
        tick();
        start0 = 0;
        for (int i = 0; i < 4; i++) tick();
        check("t2_eng_rst_rise", {31'd0, eng_rst_l0}, 32'd1);
        last0 = 1; val0 = 32'h12345678;
        tick();
        last0 = 0;
        check("t2_valid", {31'd0, result_valid0}, 32'd1);
        check("t2_result", result0, 32'h12345678);
        check("t2_run_cycles", run_cycles0, 32'd1);

        // Timeout after 16 RUN cycles.
        start = 1;
        tick();
        start = 0;
        wait_run(n);
        check("t3_rst_wait", n, 32'd4);
        for (int i = 0; i < 15; i++) tick();
        check("t3_pre_busy", {31'd0, busy}, 32'd1);
        check("t3_pre_terr", {31'd0, timeout_err}, 32'd0);
        tick();
        check("t3_terr", {31'd0, timeout_err}, 32'd1);
        check("t3_eng_rst_l", {31'd0, eng_rst_l}, 32'd0);
        check("t3_busy", {31'd0, busy}, 32'd0);
        check("t3_result", result, 32'hDEADBEEF);
        check("t3_run_cycles", run_cycles, 32'd16);
        start = 1;
        tick();
        start = 0;
        check("t3_terr_clr", {31'd0, timeout_err}, 32'd0);
        check("t3_rc_clr", run_cycles, 32'd0);
        wait_run(n);
        check("t3b_rst_wait", n, 32'd4);
        last = 1; val = 32'hA5A5A5A5;
        tick();
        last = 0;
        wait_valid(n);
        check("t3b_latency", n, 32'd14);
        check("t3b_result", result, 32'hA5A5A5A5);
        check("t3b_run_cycles", run_cycles, 32'd15);
        result_ack = 1;
        tick();
        result_ack = 0;

        // Abort mid-drain leaves the earlier result alone.
        start = 1;
        tick();
        start = 0;
        wait_run(n);
        last = 1; val = 32'h11111111;
        tick();
        last = 0;
        for (int i = 0; i < 3; i++) tick();
        abort = 1;
        tick();
        abort = 0;
        check("t4_busy", {31'd0, busy}, 32'd0);
        check("t4_eng_rst_l", {31'd0, eng_rst_l}, 32'd0);
        check("t4_result", result, 32'hA5A5A5A5);
        check("t4_valid", {31'd0, result_valid}, 32'd0);
        for (int i = 0; i < 20; i++) tick();
        check("t4_late_result", result, 32'hA5A5A5A5);
        check("t4_late_valid", {31'd0, result_valid}, 32'd0);
        start = 1; abort = 1;
        tick();
        start = 0; abort = 0;
        check("t4_start_abort", {31'd0, busy}, 32'd0);

        // Back-to-back runs with start held high.
        start = 1;
        tick();
        for (int r = 0; r < 3; r++) begin
            wait_run(n);
            check("t5_rst_wait", n, 32'd4);
            last = 1; val = 32'hB0B00000 + r;
            tick();
            last = 0;
            wait_valid(n);
            check("t5_latency", n, 32'd14);
            check("t5_result", result, 32'hB0B00000 + r);
            check("t5_run_cycles", run_cycles, 32'd15);
            if (r == 2) result_ack = 1;
            tick();
            check("t5_pulse", {31'd0, result_valid}, 32'd0);
            check("t5_restart", {31'd0, busy}, 32'd1);
        end
        result_ack = 0; start = 0; abort = 1;
        tick();
        abort = 0;
        check("t5_abort_idle", {31'd0, busy}, 32'd0);

        // Reset in RUN.
        start = 1;
        tick();
        start = 0;
        wait_run(n);
        tick();
        tick();
        rst = 1;
        tick();
        rst = 0;
        check("t6_eng_rst_l", {31'd0, eng_rst_l}, 32'd0);
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_result", result, 32'd0);
        check("t6_valid", {31'd0, result_valid}, 32'd0);
        check("t6_run_cycles", run_cycles, 32'd0);
        check("t6_terr", {31'd0, timeout_err}, 32'd0);
        tick();
        check("t6_stays_idle", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
